// File: rtl/aib_axi_link_seq.sv
// AIB/AXI link bring-up sequencer: drives conf_done, waits for both adapter
// directions online and far-side MAC ready, then holds the link up.
module aib_axi_link_seq #(
  parameter int unsigned CONF_DLY  = 16,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic       avmm_clk,
  input  logic       avmm_rst,
  input  logic       enable,
  input  logic       tx_online,
  input  logic       rx_online,
  input  logic       fs_mac_rdy,
  output logic       conf_done,
  output logic       ns_mac_rdy,
  output logic       link_up,
  output logic       credit_load,
  output logic       fail,
  output logic [2:0] retry_cnt,
  output logic [7:0] drop_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_CONF_WAIT   = 3'd1,
    S_ONLINE_WAIT = 3'd2,
    S_MAC_WAIT    = 3'd3,
    S_LINK_UP     = 3'd4,
    S_FAIL        = 3'd5
  } state_t;

  localparam logic [15:0] CONF_LAST = 16'(CONF_DLY - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  retry_q, retry_d;
  logic [7:0]  drop_q, drop_d;
  logic        cd_q, cd_d;
  logic        nr_q, nr_d;
  logic        lu_q, lu_d;
  logic        cl_q, cl_d;
  logic        fl_q, fl_d;

  logic        online_ok;
  logic        all_ok;
  logic        timed_out;
  logic [15:0] timer_inc;
  logic [7:0]  drop_inc;

  assign online_ok = tx_online & rx_online;
  assign all_ok    = online_ok & fs_mac_rdy;
  assign timed_out = (timer_q == TO_LAST);
  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 16'd1;
  assign drop_inc  = (drop_q == '1) ? drop_q : drop_q + 8'd1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_inc;
    retry_d = retry_q;
    drop_d  = drop_q;
    cd_d    = cd_q;
    nr_d    = nr_q;
    lu_d    = lu_q;
    cl_d    = 1'b0;
    fl_d    = fl_q;

    if (!enable) begin
      state_d = S_IDLE;
      timer_d = '0;
      retry_d = '0;
      cd_d    = 1'b0;
      nr_d    = 1'b0;
      lu_d    = 1'b0;
      fl_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_CONF_WAIT;
          timer_d = '0;
          retry_d = '0;
        end

        S_CONF_WAIT: begin
          if (timer_q == CONF_LAST) begin
            state_d = S_ONLINE_WAIT;
            cd_d    = 1'b1;
            timer_d = '0;
          end
        end

        // Exit condition is tested before the timeout so a late exit still wins.
        S_ONLINE_WAIT, S_MAC_WAIT: begin
          if (state_q == S_ONLINE_WAIT && online_ok) begin
            state_d = S_MAC_WAIT;
            nr_d    = 1'b1;
            timer_d = '0;
          end else if (state_q == S_MAC_WAIT && fs_mac_rdy) begin
            state_d = S_LINK_UP;
            lu_d    = 1'b1;
            cl_d    = 1'b1;
            retry_d = '0;
            timer_d = '0;
          end else if (timed_out) begin
            cd_d    = 1'b0;
            nr_d    = 1'b0;
            timer_d = '0;
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 3'd1;
              state_d = S_CONF_WAIT;
            end else begin
              state_d = S_FAIL;
              fl_d    = 1'b1;
            end
          end
        end

        S_LINK_UP: begin
          timer_d = '0;
          if (!all_ok) begin
            state_d = S_CONF_WAIT;
            cd_d    = 1'b0;
            nr_d    = 1'b0;
            lu_d    = 1'b0;
            retry_d = '0;
            drop_d  = drop_inc;
          end
        end

        S_FAIL: begin
          timer_d = '0;
        end

        default: begin
          state_d = S_IDLE;
          timer_d = '0;
          retry_d = '0;
          cd_d    = 1'b0;
          nr_d    = 1'b0;
          lu_d    = 1'b0;
          fl_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge avmm_clk or posedge avmm_rst) begin
    if (avmm_rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      retry_q <= '0;
      drop_q  <= '0;
      cd_q    <= 1'b0;
      nr_q    <= 1'b0;
      lu_q    <= 1'b0;
      cl_q    <= 1'b0;
      fl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      drop_q  <= drop_d;
      cd_q    <= cd_d;
      nr_q    <= nr_d;
      lu_q    <= lu_d;
      cl_q    <= cl_d;
      fl_q    <= fl_d;
    end
  end

  assign conf_done   = cd_q;
  assign ns_mac_rdy  = nr_q;
  assign link_up     = lu_q;
  assign credit_load = cl_q;
  assign fail        = fl_q;
  assign retry_cnt   = retry_q;
  assign drop_cnt    = drop_q;
  assign state       = state_q;

endmodule

// File: tb/tb_aib_axi_link_seq.sv
// Directed bench for aib_axi_link_seq: expected outputs are queued with each
// stimulus step and checked one time unit after the following clock edge.
module tb_aib_axi_link_seq;

  localparam int unsigned CONF_DLY  = 4;
  localparam int unsigned TIMEOUT   = 16;
  localparam int unsigned MAX_RETRY = 2;

  logic       avmm_clk = 1'b0;
  logic       avmm_rst;
  logic       enable;
  logic       tx_online;
  logic       rx_online;
  logic       fs_mac_rdy;
  logic       conf_done;
  logic       ns_mac_rdy;
  logic       link_up;
  logic       credit_load;
  logic       fail;
  logic [2:0] retry_cnt;
  logic [7:0] drop_cnt;
  logic [2:0] state;

  int compared   = 0;
  int mismatched = 0;
  int conf_rises = 0;
  int rise_base;
  logic cd_prev = 1'b0;
  logic [7:0] edc;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       cd, nr, lu, cl, fl;
    logic [2:0] rc;
    logic [7:0] dc;
  } exp_t;

  exp_t sb[$];

  always #5 avmm_clk = ~avmm_clk;

  aib_axi_link_seq #(
    .CONF_DLY (CONF_DLY),
    .TIMEOUT  (TIMEOUT),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .avmm_clk   (avmm_clk),
    .avmm_rst   (avmm_rst),
    .enable     (enable),
    .tx_online  (tx_online),
    .rx_online  (rx_online),
    .fs_mac_rdy (fs_mac_rdy),
    .conf_done  (conf_done),
    .ns_mac_rdy (ns_mac_rdy),
    .link_up    (link_up),
    .credit_load(credit_load),
    .fail       (fail),
    .retry_cnt  (retry_cnt),
    .drop_cnt   (drop_cnt),
    .state      (state)
  );

  always @(negedge avmm_clk) begin
    if (conf_done === 1'b1 && cd_prev !== 1'b1) conf_rises++;
    cd_prev = conf_done;
  end

  task automatic chk(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s.%s: observed=%0h expected=%0h", tag, fld, obs, expv);
    end
  endtask

  task automatic push(input string tag, input int st, input bit cd, nr, lu, cl, fl, input int rc);
    exp_t e;
    e.tag = tag;
    e.st  = 3'(st);
    e.cd  = cd;
    e.nr  = nr;
    e.lu  = lu;
    e.cl  = cl;
    e.fl  = fl;
    e.rc  = 3'(rc);
    e.dc  = edc;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, "state",       8'(state),       8'(e.st));
      chk(e.tag, "conf_done",   8'(conf_done),   8'(e.cd));
      chk(e.tag, "ns_mac_rdy",  8'(ns_mac_rdy),  8'(e.nr));
      chk(e.tag, "link_up",     8'(link_up),     8'(e.lu));
      chk(e.tag, "credit_load", 8'(credit_load), 8'(e.cl));
      chk(e.tag, "fail",        8'(fail),        8'(e.fl));
      chk(e.tag, "retry_cnt",   8'(retry_cnt),   8'(e.rc));
      chk(e.tag, "drop_cnt",    drop_cnt,        e.dc);
    end
  endtask

  task automatic tick();
    @(posedge avmm_clk);
    #1;
  endtask

  task automatic step(input string tag, input int st, input bit cd, nr, lu, cl, fl, input int rc);
    push(tag, st, cd, nr, lu, cl, fl, rc);
    tick();
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, observed time=%0t required below 500000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    avmm_rst   = 1'b1;
    enable     = 1'b0;
    tx_online  = 1'b0;
    rx_online  = 1'b0;
    fs_mac_rdy = 1'b0;
    edc        = 8'd0;

    // Reset state, both before and after clock edges with reset held
    #2;
    push("rst_async", 0, 0, 0, 0, 0, 0, 0);
    drain();
    tick();
    tick();
    push("rst_hold", 0, 0, 0, 0, 0, 0, 0);
    drain();
    avmm_rst = 1'b0;
    step("idle_hold0", 0, 0, 0, 0, 0, 0, 0);
    step("idle_hold1", 0, 0, 0, 0, 0, 0, 0);

    // Nominal bring-up; enable driven in cycle 0
    enable = 1'b1;
    step("nom_e1", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 2; i <= 4; i++) step("nom_conf_wait", 1, 0, 0, 0, 0, 0, 0);
    step("nom_conf_done_e5", 2, 1, 0, 0, 0, 0, 0);
    for (int i = 6; i <= 8; i++) step("nom_online_wait", 2, 1, 0, 0, 0, 0, 0);
    tx_online = 1'b1;
    rx_online = 1'b1;
    step("nom_ns_rdy_e9", 3, 1, 1, 0, 0, 0, 0);
    for (int i = 10; i <= 12; i++) step("nom_mac_wait", 3, 1, 1, 0, 0, 0, 0);
    fs_mac_rdy = 1'b1;
    step("nom_link_up_e13", 4, 1, 1, 1, 1, 0, 0);
    step("nom_credit_once", 4, 1, 1, 1, 0, 0, 0);

    // Single-cycle rx drop and automatic re-bring-up
    rx_online = 1'b0;
    edc = 8'd1;
    step("drop_first", 1, 0, 0, 0, 0, 0, 0);
    rx_online = 1'b1;
    for (int i = 1; i <= 3; i++) step("drop_conf_wait", 1, 0, 0, 0, 0, 0, 0);
    step("drop_conf_done", 2, 1, 0, 0, 0, 0, 0);
    step("drop_mac_wait", 3, 1, 1, 0, 0, 0, 0);
    step("drop_relink", 4, 1, 1, 1, 1, 0, 0);
    step("drop_credit_once", 4, 1, 1, 1, 0, 0, 0);

    // 300 more drops: the counter must stick at 255 rather than wrap
    for (int k = 0; k < 300; k++) begin
      rx_online = 1'b0;
      tick();
      rx_online = 1'b1;
      repeat (6) tick();
    end
    edc = 8'd255;
    step("drop_saturate", 4, 1, 1, 1, 0, 0, 0);

    // Disable from LINK_UP: drop_cnt is kept in IDLE
    enable     = 1'b0;
    tx_online  = 1'b0;
    rx_online  = 1'b0;
    fs_mac_rdy = 1'b0;
    step("dis_idle", 0, 0, 0, 0, 0, 0, 0);

    // Online never arrives: three attempts, then FAIL
    rise_base = conf_rises;
    enable = 1'b1;
    step("to_e1", 1, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    step("to_e4", 1, 0, 0, 0, 0, 0, 0);
    step("to_e5", 2, 1, 0, 0, 0, 0, 0);
    repeat (14) tick();
    step("to_e20_last", 2, 1, 0, 0, 0, 0, 0);
    step("to_retry1", 1, 0, 0, 0, 0, 0, 1);
    repeat (3) tick();
    step("to_conf2", 2, 1, 0, 0, 0, 0, 1);
    repeat (14) tick();
    step("to_last2", 2, 1, 0, 0, 0, 0, 1);
    step("to_retry2", 1, 0, 0, 0, 0, 0, 2);
    repeat (3) tick();
    step("to_conf3", 2, 1, 0, 0, 0, 0, 2);
    repeat (14) tick();
    step("to_last3", 2, 1, 0, 0, 0, 0, 2);
    step("to_fail", 5, 0, 0, 0, 0, 1, 2);
    step("fail_hold", 5, 0, 0, 0, 0, 1, 2);
    chk("to_conf_rises", "count", 8'(conf_rises - rise_base), 8'd3);
    enable = 1'b0;
    step("fail_clear", 0, 0, 0, 0, 0, 0, 0);

    // Online arrives in the cycle the timer reads TIMEOUT-1: exit beats timeout
    enable = 1'b1;
    step("bnd_e1", 1, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    step("bnd_e5", 2, 1, 0, 0, 0, 0, 0);
    repeat (15) tick();
    tx_online = 1'b1;
    rx_online = 1'b1;
    step("bnd_exit_wins", 3, 1, 1, 0, 0, 0, 0);
    repeat (15) tick();
    step("mac_timeout", 1, 0, 0, 0, 0, 0, 1);
    repeat (3) tick();
    step("mac_retry_conf", 2, 1, 0, 0, 0, 0, 1);
    fs_mac_rdy = 1'b1;
    step("mac_retry_online", 3, 1, 1, 0, 0, 0, 1);
    step("mac_retry_link", 4, 1, 1, 1, 1, 0, 0);

    // Asynchronous reset in the middle of MAC_WAIT
    enable = 1'b0;
    step("ar_idle", 0, 0, 0, 0, 0, 0, 0);
    fs_mac_rdy = 1'b0;
    enable = 1'b1;
    step("ar_e1", 1, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    step("ar_e5", 2, 1, 0, 0, 0, 0, 0);
    step("ar_mac_wait", 3, 1, 1, 0, 0, 0, 0);
    #2;
    avmm_rst = 1'b1;
    #1;
    edc = 8'd0;
    push("ar_async", 0, 0, 0, 0, 0, 0, 0);
    drain();
    #1;
    avmm_rst = 1'b0;
    step("ar_restart_e1", 1, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    step("ar_restart_e4", 1, 0, 0, 0, 0, 0, 0);
    step("ar_restart_e5", 2, 1, 0, 0, 0, 0, 0);
    step("ar_restart_mac", 3, 1, 1, 0, 0, 0, 0);

    // Disable in the same cycle fs_mac_rdy arrives: no credit_load
    fs_mac_rdy = 1'b1;
    enable     = 1'b0;
    step("dis_no_credit", 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
